// File: rtl/window_ctrl_pkg.sv
// rtl/window_ctrl_pkg.sv - shared widths and FSM state type for the window controller
package window_ctrl_pkg;
    localparam int PIX_W  = 8;
    localparam int WORD_W = 3 * PIX_W;
    localparam int WIN_W  = 3 * WORD_W;

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } state_t;
endpackage

// File: rtl/window_ctrl_if.sv
// rtl/window_ctrl_if.sv - pixel in, line buffer and window out signals of the window controller
interface window_ctrl_if #(
    parameter int NUM_LB = 4
);
    import window_ctrl_pkg::*;

    logic [PIX_W-1:0]         in_data;
    logic                     in_valid_data;
    logic                     in_ready;
    logic [PIX_W-1:0]         lb_wr_data;
    logic [NUM_LB-1:0]        lb_wr_valid;
    logic [NUM_LB*WORD_W-1:0] lb_rd_data;
    logic [NUM_LB-1:0]        lb_rd_ready;
    logic [WIN_W-1:0]         out_window;
    logic                     out_valid;
    logic                     out_ready;

    modport slave (
        input  in_data, in_valid_data, lb_rd_data, out_ready,
        output in_ready, lb_wr_data, lb_wr_valid, lb_rd_ready, out_window, out_valid
    );

    modport master (
        output in_data, in_valid_data, lb_rd_data, out_ready,
        input  in_ready, lb_wr_data, lb_wr_valid, lb_rd_ready, out_window, out_valid
    );
endinterface

// File: rtl/window_ctrl_mod_ptr.sv
// rtl/window_ctrl_mod_ptr.sv - modulo-N counter with a same-cycle wrap flag
module window_ctrl_mod_ptr #(
    parameter int N = 9,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt,
    output logic         o_wrap
);
    logic [W-1:0] r_cnt;

    // o_wrap is high in the cycle whose increment takes the count back to zero
    assign o_wrap = i_inc && (r_cnt == W'(N - 1));
    assign o_cnt  = r_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (o_wrap) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= r_cnt + W'(1);
        end
    end
endmodule

// File: rtl/window_ctrl.sv
// rtl/window_ctrl.sv - steers pixels round-robin into line buffers and emits registered 3x3 windows
module window_ctrl
    import window_ctrl_pkg::*;
#(
    parameter int LINE_W = 9,
    parameter int NUM_LB = 4
) (
    input  logic         clk,
    input  logic         reset,
    window_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(NUM_LB * LINE_W + 1);
    localparam int CW    = (LINE_W > 1) ? $clog2(LINE_W) : 1;
    localparam int SW    = (NUM_LB > 1) ? $clog2(NUM_LB) : 1;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_pix_cnt;
    logic [WIN_W-1:0]  r_out_window;
    logic              r_out_valid;

    logic [CW-1:0]     w_wr_cnt;
    logic [CW-1:0]     w_rd_cnt;
    logic [SW-1:0]     w_wr_sel;
    logic [SW-1:0]     w_rd_sel;
    logic              w_wr_wrap;
    logic              w_rd_wrap;
    logic              w_wr_sel_wrap;
    logic              w_rd_sel_wrap;
    logic              w_in_ready;
    logic              w_accept;
    logic              w_step;
    logic              w_capture;
    logic [NUM_LB-1:0] w_rd_mask;
    logic [WIN_W-1:0]  w_win;
    logic              w_unused;

    function automatic logic [SW-1:0] lb_idx(input logic [SW-1:0] base, input int off);
        return SW'((int'(base) + off) % NUM_LB);
    endfunction

    assign w_in_ready = (r_pix_cnt < CNT_W'(NUM_LB * LINE_W));
    assign w_accept   = bus.in_valid_data & w_in_ready;
    assign w_unused   = ^{w_wr_cnt, w_wr_sel_wrap, w_rd_sel_wrap};

    window_ctrl_mod_ptr #(.N(LINE_W), .W(CW)) u_wr_cnt (
        .clk(clk), .reset(reset), .i_inc(w_accept), .o_cnt(w_wr_cnt), .o_wrap(w_wr_wrap)
    );
    window_ctrl_mod_ptr #(.N(NUM_LB), .W(SW)) u_wr_sel (
        .clk(clk), .reset(reset), .i_inc(w_wr_wrap), .o_cnt(w_wr_sel), .o_wrap(w_wr_sel_wrap)
    );
    window_ctrl_mod_ptr #(.N(LINE_W), .W(CW)) u_rd_cnt (
        .clk(clk), .reset(reset), .i_inc(w_step), .o_cnt(w_rd_cnt), .o_wrap(w_rd_wrap)
    );
    window_ctrl_mod_ptr #(.N(NUM_LB), .W(SW)) u_rd_sel (
        .clk(clk), .reset(reset), .i_inc(w_rd_wrap), .o_cnt(w_rd_sel), .o_wrap(w_rd_sel_wrap)
    );

    // Oldest line sits in the top word of the window
    always_comb begin
        w_rd_mask = '0;
        w_win     = '0;
        for (int i = 0; i < 3; i++) begin
            w_rd_mask[lb_idx(w_rd_sel, i)] = 1'b1;
            w_win[WIN_W-1-i*WORD_W -: WORD_W] =
                bus.lb_rd_data[int'(lb_idx(w_rd_sel, i))*WORD_W +: WORD_W];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_step      = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_pix_cnt >= CNT_W'(3 * LINE_W)) begin
                    w_state_nxt = READ;
                end
            end
            READ: begin
                // The last two steps of a line only realign the buffer read pointers
                if (w_rd_cnt < CW'(LINE_W - 2)) begin
                    if (!r_out_valid || bus.out_ready) begin
                        w_step    = 1'b1;
                        w_capture = 1'b1;
                    end
                end else begin
                    w_step = 1'b1;
                end
                if (w_rd_wrap) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_pix_cnt    <= '0;
            r_out_window <= '0;
            r_out_valid  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pix_cnt <= r_pix_cnt + CNT_W'(w_accept) - (w_rd_wrap ? CNT_W'(LINE_W) : CNT_W'(0));
            if (w_capture) begin
                r_out_window <= w_win;
                r_out_valid  <= 1'b1;
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.lb_wr_data  = bus.in_data;
    assign bus.lb_wr_valid = w_accept ? (NUM_LB'(1) << w_wr_sel) : '0;
    assign bus.lb_rd_ready = w_step ? w_rd_mask : '0;
    assign bus.out_window  = r_out_window;
    assign bus.out_valid   = r_out_valid;
endmodule

// File: tb/tb_window_ctrl.sv
// tb/tb_window_ctrl.sv - self-checking bench for window_ctrl with line buffer and window models
module tb_window_ctrl;
    import window_ctrl_pkg::*;

    localparam int LINE_W = 9;
    localparam int NUM_LB = 4;
    localparam logic [71:0] FIRST_WIN = 72'h00_01_02_09_0a_0b_12_13_14;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    window_ctrl_if #(.NUM_LB(NUM_LB)) bus ();
    window_ctrl #(.LINE_W(LINE_W), .NUM_LB(NUM_LB)) dut (.clk(clk), .reset(reset), .bus(bus));

    // Line buffers: word = {mem[rp], mem[rp+1], mem[rp+2]}, oldest pixel in the top byte
    logic [7:0] mem [NUM_LB][LINE_W];
    int wp [NUM_LB];
    int rp [NUM_LB];

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NUM_LB; k++) begin
                wp[k] <= 0;
                rp[k] <= 0;
            end
        end else begin
            for (int k = 0; k < NUM_LB; k++) begin
                if (bus.lb_wr_valid[k]) begin
                    mem[k][wp[k]] <= bus.lb_wr_data;
                    wp[k] <= (wp[k] + 1) % LINE_W;
                end
                if (bus.lb_rd_ready[k]) rp[k] <= (rp[k] + 1) % LINE_W;
            end
        end
    end

    always_comb begin
        bus.lb_rd_data = '0;
        for (int k = 0; k < NUM_LB; k++)
            bus.lb_rd_data[k*24 +: 24] = {mem[k][rp[k]], mem[k][(rp[k]+1)%LINE_W], mem[k][(rp[k]+2)%LINE_W]};
    end

    int n_pass = 0;
    int n_checks = 0;

    logic [7:0]  hist [$];
    logic [71:0] exp_q [$];
    int groups_done, acc_n, step_n, win_n, model_pc, coincide_n;
    logic held, seen_1011, seen_wrap;
    logic [71:0] held_win, first_win;

    task automatic clear_model();
        hist.delete();
        exp_q.delete();
        groups_done = 0; acc_n = 0; step_n = 0; win_n = 0; model_pc = 0;
        held = 1'b0; seen_1011 = 1'b0; seen_wrap = 1'b0; first_win = '0;
    endtask

    function automatic logic [71:0] win_of(int g, int j);
        logic [71:0] w;
        w = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                w[71 - 8*(3*r + c) -: 8] = hist[LINE_W*(g + r) + j + c];
        return w;
    endfunction

    // One clock cycle: inputs already set at negedge; scoreboard the upcoming edge
    task automatic step_cycle();
        logic acc, rel, fire;
        logic [3:0] em;
        int base;
        #1;
        acc  = bus.in_valid_data & bus.in_ready;
        fire = bus.out_valid & bus.out_ready;
        rel  = 1'b0;
        if (held) begin
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.out_window !== held_win)
                $display("FAIL hold: valid=%b win=%h required 1 %h", bus.out_valid, bus.out_window, held_win);
            else n_pass++;
        end
        held = bus.out_valid & !bus.out_ready;
        held_win = bus.out_window;
        if (acc) begin
            em = 4'(1) << ((acc_n / LINE_W) % NUM_LB);
            n_checks++;
            if (bus.lb_wr_valid !== em || bus.lb_wr_data !== bus.in_data)
                $display("FAIL wr_strobe: got %b/%h required %b/%h", bus.lb_wr_valid, bus.lb_wr_data, em, bus.in_data);
            else n_pass++;
            hist.push_back(bus.in_data);
            acc_n++;
            model_pc++;
            while (hist.size() / LINE_W >= groups_done + 3) begin
                for (int j = 0; j < LINE_W - 2; j++) exp_q.push_back(win_of(groups_done, j));
                groups_done++;
            end
        end else begin
            n_checks++;
            if (bus.lb_wr_valid !== '0) $display("FAIL wr_idle: got %b required 0000", bus.lb_wr_valid);
            else n_pass++;
        end
        if (bus.lb_rd_ready !== '0) begin
            base = (step_n / LINE_W) % NUM_LB;
            em = '0;
            for (int i = 0; i < 3; i++) em[(base + i) % NUM_LB] = 1'b1;
            n_checks++;
            if (bus.lb_rd_ready !== em) $display("FAIL rd_strobe: got %b required %b", bus.lb_rd_ready, em);
            else n_pass++;
            if (em == 4'b1011) seen_1011 = 1'b1;
            if (em == 4'b0111 && seen_1011) seen_wrap = 1'b1;
            rel = ((step_n % LINE_W) == LINE_W - 1);
            step_n++;
            if (rel) model_pc -= LINE_W;
        end
        if (fire) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL window_extra: got %h required none", bus.out_window);
            end else begin
                if (bus.out_window !== exp_q[0])
                    $display("FAIL window: got %h required %h", bus.out_window, exp_q[0]);
                else n_pass++;
                void'(exp_q.pop_front());
            end
            if (win_n == 0) first_win = bus.out_window;
            win_n++;
        end
        @(posedge clk);
        #1;
        if (acc && rel) begin
            coincide_n++;
            n_checks++;
            if (int'(dut.r_pix_cnt) != model_pc)
                $display("FAIL pix_cnt_coincide: got %0d required %0d", dut.r_pix_cnt, model_pc);
            else n_pass++;
        end
        @(negedge clk);
    endtask

    task automatic apply_reset();
        bus.in_valid_data = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b0;
        reset = 1'b0;
        clear_model();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic drain(input int budget);
        bus.in_valid_data = 1'b0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < budget && (exp_q.size() != 0 || bus.out_valid); c++) step_cycle();
    endtask

    task automatic test_reset();
        bus.in_valid_data = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b0;
        reset = 1'b0;
        clear_model();
        @(negedge clk);
        n_checks++;
        if ({bus.in_ready, bus.out_valid, bus.lb_rd_ready, bus.lb_wr_valid, bus.out_window} !== {1'b1, 1'b0, 8'h00, 72'h0})
            $display("FAIL reset_held: rdy=%b ov=%b rr=%b wv=%b win=%h required 1 0 0000 0000 0",
                     bus.in_ready, bus.out_valid, bus.lb_rd_ready, bus.lb_wr_valid, bus.out_window);
        else n_pass++;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({bus.in_ready, bus.out_valid, bus.lb_rd_ready, bus.lb_wr_valid} !== {1'b1, 1'b0, 8'h00})
            $display("FAIL reset_release: rdy=%b ov=%b rr=%b wv=%b required 1 0 0000 0000",
                     bus.in_ready, bus.out_valid, bus.lb_rd_ready, bus.lb_wr_valid);
        else n_pass++;
    endtask

    task automatic test_stream();
        apply_reset();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 27; i++) begin
            bus.in_valid_data = 1'b1;
            bus.in_data = 8'(i);
            #1;
            n_checks++;
            if (bus.out_valid !== 1'b0) $display("FAIL early_valid: got %b required 0 at pixel %0d", bus.out_valid, i);
            else n_pass++;
            step_cycle();
        end
        bus.in_valid_data = 1'b0;
        for (int c = 0; c < 60 && !(step_n == LINE_W && win_n == 7); c++) step_cycle();
        repeat (10) step_cycle();
        n_checks++;
        if (step_n != LINE_W || win_n != 7) $display("FAIL stream_counts: steps=%0d windows=%0d required 9 7", step_n, win_n);
        else n_pass++;
        n_checks++;
        if (first_win !== FIRST_WIN) $display("FAIL first_window: got %h required %h", first_win, FIRST_WIN);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        logic last_rdy;
        apply_reset();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 36; i++) begin
            bus.in_valid_data = 1'b1;
            bus.in_data = 8'($urandom);
            step_cycle();
        end
        bus.in_data = 8'($urandom);
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b0 || acc_n != 36) $display("FAIL full_ready: got %b/%0d required 0/36", bus.in_ready, acc_n);
        else n_pass++;
        repeat (15) step_cycle();
        n_checks++;
        if (acc_n != 36 || step_n != 1 || bus.out_valid !== 1'b1)
            $display("FAIL stall: acc=%0d steps=%0d ov=%b required 36 1 1", acc_n, step_n, bus.out_valid);
        else n_pass++;
        n_checks++;
        if (exp_q.size() == 0 || bus.out_window !== exp_q[0])
            $display("FAIL held_window: got %h required first of %0d expected", bus.out_window, exp_q.size());
        else n_pass++;
        bus.out_ready = 1'b1;
        last_rdy = 1'b1;
        for (int c = 0; c < 40 && step_n < LINE_W; c++) begin
            #1 last_rdy = bus.in_ready;
            step_cycle();
        end
        #1;
        n_checks++;
        if (step_n != LINE_W || last_rdy !== 1'b0 || bus.in_ready !== 1'b1)
            $display("FAIL ready_recover: steps=%0d before=%b after=%b required 9 0 1", step_n, last_rdy, bus.in_ready);
        else n_pass++;
    endtask

    task automatic test_coincide();
        apply_reset();
        coincide_n = 0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 47; i++) begin
            bus.in_valid_data = (i != 27 && i != 28);
            bus.in_data = 8'($urandom);
            step_cycle();
        end
        drain(200);
        n_checks++;
        if (coincide_n == 0 || win_n != 21 || exp_q.size() != 0)
            $display("FAIL coincide: events=%0d windows=%0d left=%0d required >0 21 0", coincide_n, win_n, exp_q.size());
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int c;
        apply_reset();
        c = 0;
        while (c < 3000 && !(acc_n == 7 * LINE_W && win_n == 35)) begin
            bus.in_valid_data = (acc_n < 7 * LINE_W) && ($urandom_range(3) != 0);
            bus.in_data = 8'($urandom);
            bus.out_ready = $urandom_range(1) != 0;
            step_cycle();
            c++;
        end
        drain(100);
        n_checks++;
        if (win_n != 35 || exp_q.size() != 0 || step_n != 5 * LINE_W)
            $display("FAIL random_stream: windows=%0d left=%0d steps=%0d required 35 0 45", win_n, exp_q.size(), step_n);
        else n_pass++;
        n_checks++;
        if (seen_wrap !== 1'b1) $display("FAIL rd_sel_wrap: got %b required 1", seen_wrap);
        else n_pass++;
    endtask

    task automatic test_reset_midline();
        apply_reset();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 27; i++) begin
            bus.in_valid_data = 1'b1;
            bus.in_data = 8'(i);
            step_cycle();
        end
        bus.in_valid_data = 1'b0;
        for (int c = 0; c < 40 && step_n < 4; c++) step_cycle();
        reset = 1'b0;
        #1;
        n_checks++;
        if (step_n != 4 || bus.out_valid !== 1'b0 || dut.r_state !== IDLE || dut.r_pix_cnt !== '0 ||
            bus.lb_rd_ready !== '0 || bus.in_ready !== 1'b1)
            $display("FAIL midline_reset: steps=%0d ov=%b st=%0d pc=%0d rr=%b rdy=%b required 4 0 0 0 0000 1",
                     step_n, bus.out_valid, dut.r_state, dut.r_pix_cnt, bus.lb_rd_ready, bus.in_ready);
        else n_pass++;
        clear_model();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 27; i++) begin
            bus.in_valid_data = 1'b1;
            bus.in_data = 8'(i);
            step_cycle();
        end
        drain(60);
        n_checks++;
        if (first_win !== FIRST_WIN || win_n != 7)
            $display("FAIL restream: first=%h windows=%0d required %h 7", first_win, win_n, FIRST_WIN);
        else n_pass++;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        coincide_n = 0;
        clear_model();
        test_reset();
        test_stream();
        test_backpressure();
        test_coincide();
        test_back_to_back();
        test_reset_midline();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
